// File: rtl/ad9516_sync_pulse_gen.sv
`timescale 1ns/1ps
// Turns a one-cycle request into a delayed pulse of programmable width, then an idle hold-off.
// Typical use: driving the AD9516 SYNC pin. Offers busy/done status, retrigger-drop and abort.
module ad9516_sync_pulse_gen #(
    parameter int CNT_W     = 16,
    parameter int MIN_WIDTH = 4,
    parameter int HOLDOFF   = 8,
    parameter bit OUT_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig_in,
    input  logic [CNT_W-1:0] delay_cfg,
    input  logic [CNT_W-1:0] width_cfg,
    input  logic             abort,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             trig_drop
);

    // A single down-counter serves every phase, so it must also hold HOLDOFF-1.
    localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int CW   = (CNT_W > HO_W) ? CNT_W : HO_W;

    localparam logic [CW-1:0]    HOLD_LOAD = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [CW-1:0]    ONE_CW    = CW'(1);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_W     = CNT_W'(MIN_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_ACTIVE,
        S_HOLD
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [CNT_W-1:0] w_lat, w_n;
    logic             pulse_n, busy_n, done_n, drop_n;

    logic [CNT_W-1:0] w_clamp;
    logic [CNT_W-1:0] w_clamp_m1;
    logic [CNT_W-1:0] d_m1;
    logic [CNT_W-1:0] w_lat_m1;

    assign w_clamp    = (width_cfg < MIN_W) ? MIN_W : width_cfg;
    assign w_clamp_m1 = w_clamp - ONE_C;
    assign d_m1       = delay_cfg - ONE_C;
    assign w_lat_m1   = w_lat - ONE_C;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_n = state;
        cnt_n   = cnt;
        w_n     = w_lat;
        done_n  = 1'b0;
        drop_n  = trig_in & busy;

        unique case (state)
            S_IDLE: begin
                if (trig_in) begin
                    w_n = w_clamp;
                    if (delay_cfg == '0) begin
                        state_n = S_ACTIVE;
                        cnt_n   = CW'(w_clamp_m1);
                    end else begin
                        state_n = S_DELAY;
                        cnt_n   = CW'(d_m1);
                    end
                end
            end
            S_DELAY: begin
                if (cnt == '0) begin
                    state_n = S_ACTIVE;
                    cnt_n   = CW'(w_lat_m1);
                end else begin
                    cnt_n = cnt - ONE_CW;
                end
            end
            S_ACTIVE: begin
                if (cnt == '0) begin
                    if (HOLDOFF > 0) begin
                        state_n = S_HOLD;
                        cnt_n   = HOLD_LOAD;
                    end else begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - ONE_CW;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - ONE_CW;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Abort beats everything, including a trigger arriving in the same cycle.
        if (abort) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            w_n     = '0;
            done_n  = 1'b0;
            drop_n  = 1'b0;
        end

        busy_n  = (state_n != S_IDLE);
        pulse_n = (state_n == S_ACTIVE) ? OUT_POL : ~OUT_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            w_lat     <= '0;
            pulse_out <= ~OUT_POL;
            busy      <= 1'b0;
            done      <= 1'b0;
            trig_drop <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so all registers update together from pre-edge values.
            state     <= state_n;
            cnt       <= cnt_n;
            w_lat     <= w_n;
            pulse_out <= pulse_n;
            busy      <= busy_n;
            done      <= done_n;
            trig_drop <= drop_n;
        end
    end

endmodule

// File: tb/tb_ad9516_sync_pulse_gen.sv
`timescale 1ns/1ps
// Bench for ad9516_sync_pulse_gen: scenario table, hand-written corner sequences, and random
// stimulus compared every cycle against a timeline model (offset since accept vs D, W, HOLDOFF).
module tb_ad9516_sync_pulse_gen;

    localparam int H    = 8;
    localparam int MINW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] delay_cfg = '0;
    logic [15:0] width_cfg = '0;
    logic        pulse_out, busy, done, trig_drop;

    logic        trig_m = 1'b0;
    logic        abort_m = 1'b0;
    logic [7:0]  delay_m = '0;
    logic [7:0]  width_m = '0;
    logic        pulse_m, busy_m, done_m, drop_m;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ad9516_sync_pulse_gen #(.CNT_W(16), .MIN_WIDTH(MINW), .HOLDOFF(H), .OUT_POL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .trig_in(trig), .delay_cfg(delay_cfg), .width_cfg(width_cfg),
        .abort(abort), .pulse_out(pulse_out), .busy(busy), .done(done), .trig_drop(trig_drop)
    );

    ad9516_sync_pulse_gen #(.CNT_W(8), .MIN_WIDTH(MINW), .HOLDOFF(0), .OUT_POL(1'b0)) dut_max (
        .clk(clk), .rst_n(rst_n), .trig_in(trig_m), .delay_cfg(delay_m), .width_cfg(width_m),
        .abort(abort_m), .pulse_out(pulse_m), .busy(busy_m), .done(done_m), .trig_drop(drop_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: after the accept edge, offset k decides everything.
    bit   m_in = 1'b0;
    bit   m_busy = 1'b0;
    int   m_k = 0, m_d = 0, m_w = 0;
    logic e_pulse, e_busy, e_done, e_drop;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_in = 1'b0; m_busy = 1'b0;
            e_pulse = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_drop = 1'b0;
        end else begin
            e_drop = trig && m_busy && !abort;
            e_done = 1'b0;
            if (abort) m_in = 1'b0;
            else if (m_in) m_k++;
            else if (trig) begin
                m_in = 1'b1;
                m_k  = 0;
                m_d  = int'(delay_cfg);
                m_w  = (int'(width_cfg) < MINW) ? MINW : int'(width_cfg);
            end
            if (m_in) begin
                e_pulse = !(m_k >= m_d && m_k < m_d + m_w);
                e_busy  = (m_k < m_d + m_w + H);
                e_done  = (m_k == m_d + m_w + H);
                if (e_done) m_in = 1'b0;
            end else begin
                e_pulse = 1'b1;
                e_busy  = 1'b0;
            end
            m_busy = e_busy;
        end
        #1;
        check("model pulse_out", pulse_out, e_pulse);
        check("model busy", busy, e_busy);
        check("model done", done, e_done);
        check("model trig_drop", trig_drop, e_drop);
    end

    typedef struct {
        int d;
        int w;
        int trig2;
        int abort_at;
        int exp_start;
        int exp_end;
        int exp_done;
        int exp_drops;
    } vec_t;

    vec_t tbl[7];

    task automatic run_entry(input vec_t v, output int st, output int en, output int dn,
                             output int drops);
        st = -1; en = -1; dn = -1; drops = 0;
        @(negedge clk);
        delay_cfg = 16'(v.d);
        width_cfg = 16'(v.w);
        trig = 1'b1;
        @(posedge clk);
        #1;
        if (pulse_out == 1'b0) st = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            trig  = (k == v.trig2);
            abort = (k == v.abort_at);
            // Config churn while busy must not disturb the running sequence.
            delay_cfg = 16'(k * 7);
            width_cfg = 16'(k);
            @(posedge clk);
            #1;
            if (pulse_out == 1'b0 && st < 0) st = k;
            if (pulse_out == 1'b1 && st >= 0 && en < 0) en = k;
            if (done && dn < 0) dn = k;
            if (trig_drop) drops++;
        end
        @(negedge clk);
        trig = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int st, en, dn, drops;

        //            d  w   trig2 abort start end done drops
        tbl[0] = '{3, 10,  -1,  -1,   3,  13,  21,  0};
        tbl[1] = '{0,  1,  -1,  -1,   0,   4,  12,  0};
        tbl[2] = '{3, 10,   5,  -1,   3,  13,  21,  1};
        tbl[3] = '{3, 10,  21,  -1,   3,  13,  21,  1};
        tbl[4] = '{3, 10,  -1,   6,   3,   6,  -1,  0};
        tbl[5] = '{5,  4,  -1,  -1,   5,   9,  17,  0};
        tbl[6] = '{1,  0,  -1,  -1,   1,   5,  13,  0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++) begin
            run_entry(tbl[i], st, en, dn, drops);
            check($sformatf("tbl%0d start", i), st, tbl[i].exp_start);
            check($sformatf("tbl%0d end", i), en, tbl[i].exp_end);
            check($sformatf("tbl%0d done", i), dn, tbl[i].exp_done);
            check($sformatf("tbl%0d drops", i), drops, tbl[i].exp_drops);
        end

        // Earliest re-accept: trig at E0+22 starts a new pulse at E0+25.
        @(negedge clk);
        delay_cfg = 16'd3; width_cfg = 16'd10; trig = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            trig = (k == 22);
            @(posedge clk);
            #1;
            if (k == 23) check("reaccept no drop", trig_drop, 1'b0);
            if (k == 23) check("reaccept busy", busy, 1'b1);
            if (k == 24) check("reaccept pre-start", pulse_out, 1'b1);
            if (k == 25) check("reaccept start", pulse_out, 1'b0);
        end
        repeat (30) @(posedge clk);

        // Asynchronous reset in the middle of an active pulse.
        @(negedge clk);
        delay_cfg = 16'd0; width_cfg = 16'd10; trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        @(posedge clk);
        #1;
        check("pre-reset pulse active", pulse_out, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset pulse_out", pulse_out, 1'b1);
        check("async reset busy", busy, 1'b0);
        check("async reset done", done, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Trigger and abort together in IDLE: nothing happens.
        @(negedge clk);
        trig = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        check("trig+abort busy", busy, 1'b0);
        check("trig+abort drop", trig_drop, 1'b0);
        check("trig+abort pulse", pulse_out, 1'b1);
        @(negedge clk);
        trig = 1'b0; abort = 1'b0;
        @(posedge clk);
        #1;
        check("trig+abort later busy", busy, 1'b0);
        check("trig+abort later done", done, 1'b0);

        // Randomised traffic, checked every cycle by the model.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            trig      = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            delay_cfg = 16'($urandom_range(0, 6));
            width_cfg = 16'($urandom_range(0, 12));
        end
        @(negedge clk);
        trig = 1'b0; abort = 1'b0;
        repeat (40) @(posedge clk);

        // Full-scale counts on the 8-bit, zero-holdoff instance.
        begin
            int ms, me, md;
            ms = -1; me = -1; md = -1;
            @(negedge clk);
            delay_m = 8'd255; width_m = 8'd255; trig_m = 1'b1;
            @(posedge clk);
            #1;
            if (pulse_m == 1'b0) ms = 0;
            for (int k = 1; k <= 520; k++) begin
                @(negedge clk);
                trig_m = 1'b0;
                @(posedge clk);
                #1;
                if (pulse_m == 1'b0 && ms < 0) ms = k;
                if (pulse_m == 1'b1 && ms >= 0 && me < 0) me = k;
                if (done_m && md < 0) md = k;
                if (k == 509) check("max busy before end", busy_m, 1'b1);
                if (k == 510) check("max busy at end", busy_m, 1'b0);
            end
            check("max start", ms, 255);
            check("max end", me, 510);
            check("max done", md, 510);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
